// File: rtl/vec_data_mem_if.sv
// Request/response bundle for the vector data memory.
// The requester uses the master modport and the memory uses the slave modport.
interface vec_data_mem_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic [LANES*LANE_W-1:0]   req_wdata;
  logic [LANES-1:0]          req_lane_mask;
  logic                      rsp_valid;
  logic [LANES*LANE_W-1:0]   rsp_rdata;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lane_mask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lane_mask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/vec_data_mem.sv
// Single-port lane-masked vector data memory with a registered read response.
// After reset, a sweep writes zero to one word per cycle until the whole array is clear.
module vec_data_mem #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 129,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  vec_data_mem_if.slave   bus
);
  localparam int W     = LANES * LANE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_addr_q, clr_addr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [W-1:0]     mem_q [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [W-1:0]     mem_wdata;

  logic             busy;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] req_idx;
  logic [W-1:0]     cur_word;
  logic [W-1:0]     lane_bits;

  // Reset itself counts as busy so no request slips in on a reset edge.
  assign busy     = rst || (state_q == ST_CLEAR);
  assign accept   = bus.req_valid && !busy;
  assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
  assign req_idx  = in_range ? IDX_W'(bus.req_addr) : '0;
  assign cur_word = mem_q[req_idx];

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_bits[i*LANE_W +: LANE_W] = {LANE_W{bus.req_lane_mask[i]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = (bus.req_wdata & lane_bits) | (cur_word & ~lane_bits);
    rsp_valid_d = accept;
    rsp_err_d   = accept && !in_range;
    rsp_rdata_d = (accept && !bus.req_we && in_range) ? (cur_word & lane_bits) : '0;

    case (state_q)
      ST_CLEAR: begin
        if (!rst) begin
          mem_we     = 1'b1;
          mem_waddr  = clr_addr_q;
          mem_wdata  = '0;
          clr_addr_d = clr_addr_q + IDX_W'(1);
          if (clr_addr_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
          end
        end
      end
      ST_IDLE: begin
        mem_we = accept && bus.req_we && in_range;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The array has no reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.req_ready = !busy;
  assign bus.busy      = busy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_vec_data_mem.sv
// Scoreboard bench for vec_data_mem: a lane-masked memory model predicts every response.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vec_data_mem;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int DEPTH  = 129;
  localparam int ADDR_W = 8;
  localparam int W      = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_data_mem_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus_if ();

  vec_data_mem #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    string        tag;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model [DEPTH];
  int           checks    = 0;
  int           passed    = 0;
  int           rsp_count = 0;
  logic         acc_prev  = 1'b0;
  logic         acc_now   = 1'b0;
  logic         busy_seen = 1'b0;
  bit           mon_en    = 1'b0;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Every accepted request must answer exactly one cycle later; idle outputs stay zero.
  task automatic monitorCycle();
    exp_t e;
    if (!mon_en) return;
    checkOutput("rsp_valid", W'(bus_if.rsp_valid), W'(acc_prev));
    if (bus_if.rsp_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_rdata"}, bus_if.rsp_rdata, e.rdata);
      checkOutput({e.tag, "_err"}, W'(bus_if.rsp_err), W'(e.err));
      rsp_count++;
    end else if (bus_if.rsp_valid !== 1'b1) begin
      checkOutput("idle_rdata", bus_if.rsp_rdata, '0);
      checkOutput("idle_err", W'(bus_if.rsp_err), '0);
    end
  endtask

  task automatic applyStimulus(input logic rst_in, input logic valid, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [W-1:0] data,
                               input logic [LANES-1:0] mask, input string tag);
    exp_t         e;
    logic [W-1:0] bits;
    @(negedge clk);
    monitorCycle();
    rst                  = rst_in;
    bus_if.req_valid     = valid;
    bus_if.req_we        = we;
    bus_if.req_addr      = addr;
    bus_if.req_wdata     = data;
    bus_if.req_lane_mask = mask;
    #1;
    busy_seen = bus_if.busy;
    if (mon_en) checkOutput("ready_vs_busy", W'(bus_if.req_ready), W'(!bus_if.busy));
    acc_now = valid && (bus_if.req_ready === 1'b1);
    if (acc_now) begin
      bits = '0;
      for (int i = 0; i < LANES; i++) if (mask[i]) bits[i*LANE_W +: LANE_W] = '1;
      e.tag   = tag;
      e.rdata = '0;
      e.err   = 1'b0;
      if (int'(addr) >= DEPTH) e.err = 1'b1;
      else if (we) model[addr] = (data & bits) | (model[addr] & ~bits);
      else e.rdata = model[addr] & bits;
      exp_q.push_back(e);
    end
    acc_prev = acc_now;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "idle");
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, "rst");
      mon_en = 1'b1;
    end
  endtask

  // Counts sampled busy cycles after reset release, bounded so a stuck sweep cannot hang.
  task automatic countClear(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "idle");
      if (busy_seen === 1'b1) n++;
      else break;
    end
  endtask

  int n;
  int rsp_before;

  initial begin
    bus_if.req_valid     = 1'b0;
    bus_if.req_we        = 1'b0;
    bus_if.req_addr      = '0;
    bus_if.req_wdata     = '0;
    bus_if.req_lane_mask = '0;

    doReset(2);
    countClear(n);
    checkOutput("t1_clear_cycles", W'(n), W'(129));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0,   '0, 4'b1111, "t1_rd0");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd64,  '0, 4'b1111, "t1_rd64");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd128, '0, 4'b1111, "t1_rd128");
    idle(2);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5, 128'h44444444_33333333_22222222_11111111, 4'b1111, "t2_wr5");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, '0, 4'b1111, "t2_rd5");
    idle(2);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5, '1, 4'b0101, "t3_wr5");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, '0, 4'b1111, "t3_rd5_full");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, '0, 4'b0011, "t3_rd5_low");
    idle(2);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, {4{32'hDEADBEEF}}, 4'b1111, "t4_wr200");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd200, '0, 4'b1111, "t4_rd200");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5,   '0, 4'b1111, "t4_rd5");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd72,  '0, 4'b1111, "t4_rd72");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd128, '0, 4'b1111, "t4_rd128");
    idle(2);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd10, 128'hA5A5A5A5_0BADF00D_12345678_CAFEF00D, 4'b1111, "t5_wr10");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd10, '0, 4'b1111, "t5_rd10_pre");
    idle(2);
    doReset(2);
    idle(50);
    doReset(2);
    countClear(n);
    checkOutput("t5_restart_cycles", W'(n), W'(129));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd10, '0, 4'b1111, "t5_rd10_post");
    idle(2);

    doReset(2);
    n = 0;
    rsp_before = rsp_count;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, '0, 4'b1111, "t6_rd5");
      n++;
      if (acc_now) break;
    end
    checkOutput("t6_accept_cycle", W'(n), W'(130));
    idle(3);
    checkOutput("t6_one_response", W'(rsp_count - rsp_before), W'(1));
    checkOutput("queue_drained", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
